// File: rtl/mem_access_unit.sv
// Load/store bus initiator: serialises byte/halfword/word accesses into single-byte
// little-endian memory transactions and returns extended load data with a done pulse.
module mem_access_unit #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_adr,
    output logic [7:0]    mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] base_p0;
    logic [31:0]   wbuf_p0;
    logic [31:0]   asm_p0;
    logic [31:0]   asm_nxt;
    logic          we_p0;
    logic          uns_p0;
    logic [1:0]    size_p0;
    logic [1:0]    cnt_p0;
    logic [1:0]    last;

    // Fill bits above the loaded width with the top data bit, or zeros when unsigned.
    function automatic logic signed [31:0] extend(input logic [31:0] v,
                                                  input logic [1:0]  sz,
                                                  input logic        u);
        logic signed [31:0] r;
        case (sz)
            2'b00:   r = {{24{v[7]  & ~u}}, v[7:0]};
            2'b01:   r = {{16{v[15] & ~u}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        case (size_p0)
            2'b00:   last = 2'd0;
            2'b01:   last = 2'd1;
            default: last = 2'd3;
        endcase
    end

    // The bus address and byte lane follow the counter, so both hold outside XFER.
    assign mem_adr   = base_p0 + {{(AW-2){1'b0}}, cnt_p0};
    assign mem_wdata = wbuf_p0[{cnt_p0, 3'b000} +: 8];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        asm_nxt   = asm_p0;
        asm_nxt[{cnt_p0, 3'b000} +: 8] = mem_rdata;
        case (state)
            IDLE: begin
                if (req) state_nxt = XFER;
            end
            XFER: begin
                busy = 1'b1;
                // Enables are gated by reset so an aborting edge never commits a byte.
                mem_read  = ~we_p0 & ~rst;
                mem_write = we_p0 & ~rst;
                if (cnt_p0 == last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt_p0  <= 2'd0;
            base_p0 <= '0;
            wbuf_p0 <= 32'd0;
            asm_p0  <= 32'd0;
            rdata   <= 32'd0;
            we_p0   <= 1'b0;
            uns_p0  <= 1'b0;
            size_p0 <= 2'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        base_p0 <= addr;
                        wbuf_p0 <= wdata;
                        we_p0   <= we;
                        uns_p0  <= uns;
                        size_p0 <= size;
                        cnt_p0  <= 2'd0;
                        asm_p0  <= 32'd0;
                    end
                end
                XFER: begin
                    if (!we_p0) asm_p0 <= asm_nxt;
                    if (cnt_p0 == last) begin
                        if (!we_p0) rdata <= extend(asm_nxt, size_p0, uns_p0);
                    end else begin
                        cnt_p0 <= cnt_p0 + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Bus initiator between the CPU load/store path and the byte-addressed data memory.
- Accepts one load or store request (byte, halfword or word) from the core.
- Serialises the request into single-byte memory transactions, little-endian: byte k of the operand lives at address addr+k.
- Assembles and sign/zero-extends load data; signals completion with a one-cycle done pulse.

Parameters:
AW, 32, width of address bus on both core and memory sides

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  1  core request; sampled only in IDLE
we  input  1  1 = store, 0 = load; sampled with req
size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
uns  input  1  loads only: 1 = zero-extend, 0 = sign-extend
addr  input  AW  byte address of the access (any alignment)
wdata  input  32  store data; low-order bytes are used
rdata  output  32  extended load result, held until the next accept
busy  output  1  high while a request is in progress (XFER)
done  output  1  one-cycle completion pulse
mem_adr  output  AW  byte address to memory
mem_wdata  output  8  byte to write
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable; memory writes at the rising edge
mem_rdata  input  8  combinational read byte from memory at mem_adr

Behaviour:
- Reset values:
  - State is IDLE.
  - rdata, mem_adr and mem_wdata are 0.
  - busy, done, mem_read and mem_write are 0.
- Byte count n: 1 for byte, 2 for halfword, 4 for word or size=11.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - When req=1, latch addr, wdata, we, size and uns; clear byte counter cnt; clear the assembly register.
  - Transition to XFER. The request is accepted on this edge.
  - req=0 keeps the unit in IDLE.
- XFER:
  - busy=1.
  - mem_adr = base + cnt, modulo 2^AW, so addresses wrap past all-ones to 0.
  - For a load: mem_read=1, mem_write=0. mem_rdata is captured into byte lane cnt at the edge.
  - For a store: mem_write=1, mem_read=0, mem_wdata = wdata byte cnt. Bytes at cnt >= n are never written.
  - If cnt == n-1, go to DONE; otherwise increment cnt.
  - Exactly n memory cycles per request. mem_read and mem_write are never both 1.
- DONE:
  - done=1 and busy=0; mem_read and mem_write are 0.
  - For loads, rdata is updated on the edge entering DONE and is valid while done=1.
  - Extension: bits above 8n are filled with bit 8n-1 if uns=0, or zeros if uns=1.
  - For stores, rdata is unchanged.
  - Unconditionally returns to IDLE.
- Latency: a request accepted at edge N gives done high in the cycle after edge N+n.
  - Word: 5 cycles from req to done.
  - Byte: 2 cycles from req to done.
- req during XFER or DONE is ignored, not queued. Holding req high gives back-to-back operations, each starting from IDLE.
- Input changes after accept have no effect on the in-flight access.
- Reset mid-operation: the next state is IDLE.
  - mem_read and mem_write drop at the reset edge; done never pulses; rdata is cleared.
  - Bytes already written stay in memory.
- In IDLE and DONE, mem_adr and mem_wdata hold their last values. Only the enables qualify the bus.

Test Plan:
- Word load: memory bytes 0x10..0x13 = 78,56,34,12; LW addr=0x10.
  - mem_adr sequence 0x10, 0x11, 0x12, 0x13 with mem_read=1 for 4 cycles.
  - done in cycle 5 with rdata=0x12345678.
- Byte load extension: byte 0x20 = 0x85.
  - LB (uns=0) gives rdata=0xFFFFFF85.
  - LBU (uns=1) gives rdata=0x00000085.
  - Each completes with done 2 cycles after req.
- Halfword store: SH addr=0x31, wdata=0xAABBCCDD.
  - Writes 0xDD to 0x31 and 0xCC to 0x32.
  - mem_write high for exactly 2 cycles; 0x30 and 0x33 are unchanged.
- Reset mid-store: SW addr=0x40, wdata=0x11223344, rst asserted in the 3rd XFER cycle.
  - Only 0x40=0x44 and 0x41=0x33 are written.
  - busy=0 and mem_write=0 after the reset edge; done never asserts.
- Wrap and back-to-back: LW addr=0xFFFFFFFE with req held high.
  - mem_adr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
  - The second request is accepted in the IDLE cycle immediately after done.
  - Each request produces exactly one done pulse.
